// File: rtl/decoy_cfg_sequencer.sv
// Decoy reconfiguration sequencer: streams an RNG pattern table into the decoy dpram,
// latches the table length, then issues a stretched reg_enable commit followed by a quiet gap.
module decoy_cfg_sequencer #(
    parameter int unsigned ENABLE_HOLD = 16,
    parameter int unsigned ENABLE_GAP  = 16,
    parameter int unsigned WORDS_MAX   = 8
) (
    input  logic        s_axil_aclk,
    input  logic        s_axil_aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        tbl_tvalid,
    output logic        tbl_tready,
    input  logic [31:0] tbl_tdata,
    input  logic        tbl_tlast,
    output logic        rng_wen_o,
    output logic [2:0]  rng_addr_o,
    output logic [31:0] rng_din_o,
    output logic [5:0]  max_addr_o,
    output logic        reg_enable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_overflow_o
);

    localparam int unsigned CntMax = (ENABLE_HOLD > ENABLE_GAP) ? ENABLE_HOLD : ENABLE_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned AddrW  = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StPulse, StGap} state_t;

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic [AddrW-1:0]  wcnt;
    logic              last_word;

    assign cmd_ready  = (state == StIdle);
    assign tbl_tready = (state == StLoad) || (state == StDrain);
    assign busy_o     = (state != StIdle);
    assign last_word  = (32'(wcnt) == WORDS_MAX - 1);

    // cnt tracks commit cycles already issued (PULSE) or quiet cycles elapsed (GAP).
    // A load enters PULSE with cnt=0 so reg_enable rises one cycle after the final write;
    // COMMIT_ONLY has no pending write and raises reg_enable straight away.
    always_ff @(posedge s_axil_aclk) begin
        if (!s_axil_aresetn) begin
            state          <= StIdle;
            cnt            <= '0;
            wcnt           <= '0;
            rng_wen_o      <= 1'b0;
            rng_addr_o     <= '0;
            rng_din_o      <= '0;
            max_addr_o     <= '0;
            reg_enable_o   <= 1'b0;
            done_o         <= 1'b0;
            err_overflow_o <= 1'b0;
        end else begin
            rng_wen_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'd1: begin
                                state          <= StLoad;
                                wcnt           <= '0;
                                err_overflow_o <= 1'b0;
                            end
                            2'd2: begin
                                state        <= StPulse;
                                reg_enable_o <= 1'b1;
                                cnt          <= CntW'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                StLoad: begin
                    if (tbl_tvalid) begin
                        rng_wen_o  <= 1'b1;
                        rng_addr_o <= 3'(wcnt);
                        rng_din_o  <= tbl_tdata;
                        wcnt       <= wcnt + 1'b1;
                        if (tbl_tlast) begin
                            max_addr_o <= 6'((32'(wcnt) + 32'd1) * 32'd8);
                            state      <= StPulse;
                            cnt        <= '0;
                        end else if (last_word) begin
                            err_overflow_o <= 1'b1;
                            max_addr_o     <= '0;
                            state          <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (tbl_tvalid && tbl_tlast) begin
                        state <= StPulse;
                        cnt   <= '0;
                    end
                end
                StPulse: begin
                    if (cnt == CntW'(ENABLE_HOLD)) begin
                        reg_enable_o <= 1'b0;
                        cnt          <= CntW'(1);
                        state        <= StGap;
                    end else begin
                        reg_enable_o <= 1'b1;
                        cnt          <= cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt == CntW'(ENABLE_GAP)) begin
                        state  <= StIdle;
                        done_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_decoy_cfg_sequencer.sv
// Directed bench for decoy_cfg_sequencer: table of command vectors with hand-computed
// write/commit timing, plus hand-written reset sequences.
module tb_decoy_cfg_sequencer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        tbl_tvalid;
    logic        tbl_tready;
    logic [31:0] tbl_tdata;
    logic        tbl_tlast;
    logic        rng_wen_o;
    logic [2:0]  rng_addr_o;
    logic [31:0] rng_din_o;
    logic [5:0]  max_addr_o;
    logic        reg_enable_o;
    logic        busy_o;
    logic        done_o;
    logic        err_overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoy_cfg_sequencer #(
        .ENABLE_HOLD(16),
        .ENABLE_GAP (16),
        .WORDS_MAX  (8)
    ) dut (
        .s_axil_aclk   (clk),
        .s_axil_aresetn(aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .tbl_tvalid    (tbl_tvalid),
        .tbl_tready    (tbl_tready),
        .tbl_tdata     (tbl_tdata),
        .tbl_tlast     (tbl_tlast),
        .rng_wen_o     (rng_wen_o),
        .rng_addr_o    (rng_addr_o),
        .rng_din_o     (rng_din_o),
        .max_addr_o    (max_addr_o),
        .reg_enable_o  (reg_enable_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_overflow_o(err_overflow_o)
    );

    // Timing fields are cycle offsets from the command-accept edge (t=1 is the first
    // cycle after acceptance); -1 means the event must never happen.
    typedef struct {
        logic [1:0]  op;
        int          nwords;
        bit          toggle;
        int          exp_writes;
        logic [5:0]  exp_max;
        bit          exp_err;
        int          exp_rise;
        int          exp_high;
        int          exp_done;
        int          exp_busy;
        int          exp_tready;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wdata(input int id, input int i);
        if (id == 0) return (i == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
        return 32'h1000_0000 * id + 32'h0101_0101 * i;
    endfunction

    // Entered at #1 after a posedge with the DUT idle; leaves at the same phase.
    task automatic run_vec(input vec_t v, input int id);
        logic [2:0]  wa[16];
        logic [31:0] wd[16];
        int nw = 0, high = 0, rise = -1, dcnt = 0, dcyc = -1, busy = 0, trdy = 0, sent = 0;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        for (int t = 1; t <= 60; t++) begin
            if (rng_wen_o) begin
                if (nw < 16) begin
                    wa[nw] = rng_addr_o;
                    wd[nw] = rng_din_o;
                end
                nw++;
            end
            if (reg_enable_o) begin
                high++;
                if (rise < 0) rise = t;
            end
            if (done_o) begin
                dcnt++;
                if (dcyc < 0) dcyc = t;
            end
            if (!cmd_ready) busy++;
            if (sent < v.nwords && (!v.toggle || (t % 2) == 1)) begin
                tbl_tvalid = 1'b1;
                tbl_tdata  = wdata(id, sent);
                tbl_tlast  = (sent == v.nwords - 1);
            end else begin
                tbl_tvalid = 1'b0;
                tbl_tlast  = 1'b0;
            end
            if (tbl_tready) trdy++;
            if (tbl_tvalid && tbl_tready) sent++;
            @(posedge clk); #1;
        end
        tbl_tvalid = 1'b0;
        tbl_tlast  = 1'b0;
        chk($sformatf("v%0d writes", id), nw, v.exp_writes);
        for (int k = 0; k < nw && k < 16; k++) begin
            chk($sformatf("v%0d addr%0d", id, k), 32'(wa[k]), k);
            chk($sformatf("v%0d data%0d", id, k), wd[k], wdata(id, k));
        end
        chk($sformatf("v%0d max_addr", id), 32'(max_addr_o), 32'(v.exp_max));
        chk($sformatf("v%0d err", id), 32'(err_overflow_o), 32'(v.exp_err));
        chk($sformatf("v%0d rise", id), rise, v.exp_rise);
        chk($sformatf("v%0d high", id), high, v.exp_high);
        chk($sformatf("v%0d done_cnt", id), dcnt, (v.exp_done >= 0) ? 1 : 0);
        chk($sformatf("v%0d done_cyc", id), dcyc, v.exp_done);
        chk($sformatf("v%0d busy", id), busy, v.exp_busy);
        chk($sformatf("v%0d tready", id), trdy, v.exp_tready);
    endtask

    vec_t vecs[8];
    vec_t post;

    initial begin
        int dcnt;
        //          op    n   tog writes max    err rise high done busy trdy
        vecs[0] = '{2'd1, 2,  0,  2,  6'd16, 0,  4,  16,  36,  35,  2};
        vecs[1] = '{2'd1, 8,  0,  8,  6'd0,  0,  10, 16,  42,  41,  8};
        vecs[2] = '{2'd1, 10, 0,  8,  6'd0,  1,  12, 16,  44,  43,  10};
        vecs[3] = '{2'd1, 1,  0,  1,  6'd8,  0,  3,  16,  35,  34,  1};
        vecs[4] = '{2'd2, 1,  0,  0,  6'd8,  0,  1,  16,  33,  32,  0};
        vecs[5] = '{2'd1, 3,  1,  3,  6'd24, 0,  7,  16,  39,  38,  5};
        vecs[6] = '{2'd0, 1,  0,  0,  6'd24, 0,  -1, 0,   -1,  0,   0};
        vecs[7] = '{2'd3, 1,  0,  0,  6'd24, 0,  -1, 0,   -1,  0,   0};
        post    = '{2'd2, 0,  0,  0,  6'd0,  0,  1,  16,  33,  32,  0};

        aresetn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        tbl_tvalid = 1'b0;
        tbl_tdata  = '0;
        tbl_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst rng_wen", 32'(rng_wen_o), 0);
        chk("rst reg_enable", 32'(reg_enable_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst done", 32'(done_o), 0);
        chk("rst err", 32'(err_overflow_o), 0);
        chk("rst max_addr", 32'(max_addr_o), 0);
        chk("rst tready", 32'(tbl_tready), 0);
        chk("rst cmd_ready", 32'(cmd_ready), 1);
        chk("rst addr_din", {29'(rng_din_o), rng_addr_o}, 0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset landing in the 5th commit cycle of a COMMIT_ONLY.
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        chk("pre-rst reg_enable t1", 32'(reg_enable_o), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("pre-rst busy t5", 32'(busy_o), 1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        chk("mid-rst reg_enable", 32'(reg_enable_o), 0);
        chk("mid-rst busy", 32'(busy_o), 0);
        chk("mid-rst max_addr", 32'(max_addr_o), 0);
        aresetn = 1'b1;
        dcnt = 0;
        for (int t = 0; t < 40; t++) begin
            if (done_o || reg_enable_o) dcnt++;
            @(posedge clk); #1;
        end
        chk("post-rst no done/enable", dcnt, 0);
        run_vec(post, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
